mac_sequencer: RTL and testbench

- Upstream controller and downstream consumer for the shared 32-bit iterative multiplier.
- Accepts a job (term count, bias, sign and word-select mode) and a valid/ready stream of operand pairs.
- Issues one multiply per pair and waits for the multiplier's ready pulse.
- Accumulates products onto the bias and returns one 32-bit dot-product result per job for the classifier's fully-connected layers.

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_acc_add.sv | 37 +++
 rtl/mac_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mac_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC sequencer and its accumulator adder.
// The optional clamp (MAC_SATURATE_EN) lives in mac_acc_add.
package mac_pkg;

    localparam int unsigned ACC_W_DEFAULT = 32;
    localparam int unsigned DATA_W        = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_ACCUM = 3'd4,
        S_DONE  = 3'd5
    } mac_state_t;

    localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG = 32'h8000_0000;
    localparam logic [31:0] SAT_U   = 32'hFFFF_FFFF;

endpackage

// File: rtl/mac_acc_add.sv
// Accumulator adder with signed/unsigned overflow detect.
// With MAC_SATURATE_EN defined the sum clamps on overflow; otherwise it wraps.
module mac_acc_add
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [ACC_W-1:0] addend_i,
    input  logic             sign_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    logic [ACC_W:0] raw_c;
    logic           ovf_s_c;
    logic           ovf_u_c;

    always_comb begin
        raw_c   = {1'b0, acc_i} + {1'b0, addend_i};
        ovf_s_c = (acc_i[ACC_W-1] == addend_i[ACC_W-1]) && (raw_c[ACC_W-1] != acc_i[ACC_W-1]);
        ovf_u_c = raw_c[ACC_W];
        ovf_o   = sign_i ? ovf_s_c : ovf_u_c;
        sum_o   = raw_c[ACC_W-1:0];
`ifdef MAC_SATURATE_EN
        // Signed overflow only happens when both operands share acc's sign.
        if (ovf_o) begin
            if (sign_i) begin
                sum_o = acc_i[ACC_W-1] ? ACC_W'(SAT_NEG) : ACC_W'(SAT_POS);
            end else begin
                sum_o = ACC_W'(SAT_U);
            end
        end
`endif
    end

endmodule

// File: rtl/mac_sequencer.sv
// Drives the shared iterative multiplier one operand pair at a time and
// accumulates products onto a bias; one result strobe per job. Option: MAC_SATURATE_EN.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int unsigned LEN_W = 16,
    parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              sign_i,
    input  logic              up_or_low_i,
    input  logic [ACC_W-1:0]  bias_i,
    input  logic              op_valid_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic              op_ready_o,
    output logic              mult_enable_o,
    output logic [DATA_W-1:0] mult_a_o,
    output logic [DATA_W-1:0] mult_b_o,
    output logic              mult_sign_o,
    output logic              mult_up_or_low_o,
    input  logic [DATA_W-1:0] mult_product_i,
    input  logic              mult_ready_i,
    output logic              busy_o,
    output logic [ACC_W-1:0]  result_o,
    output logic              result_valid_o,
    output logic              overflow_o
);

    mac_state_t        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic              ul_q, ul_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] prod_q, prod_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic              rv_q, rv_d;
    logic              en_q, en_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  sum_c;
    logic              add_ovf_c;

    mac_acc_add #(.ACC_W(ACC_W)) u_add (
        .acc_i    (acc_q),
        .addend_i (ACC_W'(prod_q)),
        .sign_i   (sign_q),
        .sum_o    (sum_c),
        .ovf_o    (add_ovf_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            ul_q     <= 1'b0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            en_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            ul_q     <= ul_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            en_q     <= en_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state; en_d/rv_d are set on the transition so the strobes land in ISSUE / after DONE.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        ul_d     = ul_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        result_d = result_q;
        rv_d     = 1'b0;
        en_d     = 1'b0;
        ovf_d    = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d   = len_i;
                    sign_d  = sign_i;
                    ul_d    = up_or_low_i;
                    acc_d   = bias_i;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len_i == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (op_valid_i) begin
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    en_d    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mult_ready_i) begin
                    prod_d  = mult_product_i;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d   = sum_c;
                ovf_d   = ovf_q | add_ovf_c;
                cnt_d   = LEN_W'(cnt_q + LEN_W'(1));
                state_d = (LEN_W'(cnt_q + LEN_W'(1)) == len_q) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                result_d = acc_q;
                rv_d     = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign op_ready_o       = (state_q == S_FETCH);
    assign busy_o           = (state_q != S_IDLE);
    assign mult_enable_o    = en_q;
    assign mult_a_o         = a_q;
    assign mult_b_o         = b_q;
    assign mult_sign_o      = sign_q;
    assign mult_up_or_low_o = ul_q;
    assign result_o         = result_q;
    assign result_valid_o   = rv_q;
    assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer with a 35-cycle behavioural multiplier.
// Expectations follow the MAC_SATURATE_EN setting of the build.
module tb_mac_sequencer;

    localparam int MULT_LAT = 35;

    typedef struct packed {
        logic [15:0]      len;
        logic             sign;
        logic             ul;
        logic [31:0]      bias;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        logic [31:0]      exp_res;
        logic             exp_ovf;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic [15:0] nen;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [15:0] len_i;
    logic        sign_i;
    logic        up_or_low_i;
    logic [31:0] bias_i;
    logic        op_valid_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        op_ready_o;
    logic        mult_enable_o;
    logic [31:0] mult_a_o;
    logic [31:0] mult_b_o;
    logic        mult_sign_o;
    logic        mult_up_or_low_o;
    logic [31:0] mult_product_i;
    logic        mult_ready_i;
    logic        busy_o;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic        overflow_o;

    int   checks;
    int   failures;
    exp_t exp_q[$];
    int   en_cnt;
    int   wide_cnt;
    logic en_prev;
    vec_t vecs[8];

    logic        model_rdy;
    logic [31:0] model_prod;
    int          mcnt;
    logic        stray_rdy;

    mac_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .start_i          (start_i),
        .len_i            (len_i),
        .sign_i           (sign_i),
        .up_or_low_i      (up_or_low_i),
        .bias_i           (bias_i),
        .op_valid_i       (op_valid_i),
        .op_a_i           (op_a_i),
        .op_b_i           (op_b_i),
        .op_ready_o       (op_ready_o),
        .mult_enable_o    (mult_enable_o),
        .mult_a_o         (mult_a_o),
        .mult_b_o         (mult_b_o),
        .mult_sign_o      (mult_sign_o),
        .mult_up_or_low_o (mult_up_or_low_o),
        .mult_product_i   (mult_product_i),
        .mult_ready_i     (mult_ready_i),
        .busy_o           (busy_o),
        .result_o         (result_o),
        .result_valid_o   (result_valid_o),
        .overflow_o       (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mult_ready_i   = model_rdy | stray_rdy;
    assign mult_product_i = model_rdy ? model_prod : 32'hDEAD_BEEF;

    function automatic logic [31:0] mul_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic s, input logic ul);
        logic [63:0] p;
        if (s) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        else   p = {32'd0, a} * {32'd0, b};
        return ul ? p[63:32] : p[31:0];
    endfunction

    // Behavioural multiplier: ready pulse MULT_LAT cycles after the enable cycle.
    always @(negedge clk) begin
        if (reset) begin
            mcnt      = 0;
            model_rdy = 1'b0;
        end else begin
            model_rdy = 1'b0;
            if (mcnt > 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) model_rdy = 1'b1;
            end
            if (mult_enable_o) begin
                mcnt       = MULT_LAT;
                model_prod = mul_f(mult_a_o, mult_b_o, mult_sign_o, mult_up_or_low_o);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One cycle: advance to the negedge, then monitor enables and result strobes.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (reset) begin
            en_cnt  = 0;
            en_prev = 1'b0;
        end else begin
            if (mult_enable_o) begin
                en_cnt++;
                if (en_prev) wide_cnt++;
            end
            en_prev = mult_enable_o;
            if (result_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(result_valid_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result_o, e.res);
                    chk("overflow", 32'(overflow_o), 32'(e.ovf));
                    chk("enable_pulses", 32'(en_cnt), 32'(e.nen));
                end
                en_cnt = 0;
            end
        end
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 200 && !op_ready_o; k++) tick();
        chk("ready_timeout", 32'(op_ready_o), 32'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400 && busy_o; k++) tick();
        chk("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    task automatic drive_start(input logic [15:0] len, input logic s, input logic ul,
                               input logic [31:0] bias);
        start_i     = 1'b1;
        len_i       = len;
        sign_i      = s;
        up_or_low_i = ul;
        bias_i      = bias;
        tick();
        start_i = 1'b0;
    endtask

    task automatic give_pair(input logic [31:0] a, input logic [31:0] b);
        wait_ready();
        op_valid_i = 1'b1;
        op_a_i     = a;
        op_b_i     = b;
        tick();
        op_valid_i = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        exp_q.push_back('{res: v.exp_res, ovf: v.exp_ovf, nen: v.len});
        drive_start(v.len, v.sign, v.ul, v.bias);
        for (int i = 0; i < int'(v.len); i++) give_pair(v.a[i], v.b[i]);
        wait_idle();
    endtask

    function automatic vec_t mk(input logic [15:0] len, input logic s, input logic ul,
                                input logic [31:0] bias,
                                input logic [31:0] a0, input logic [31:0] b0,
                                input logic [31:0] a1, input logic [31:0] b1,
                                input logic [31:0] a2, input logic [31:0] b2,
                                input logic [31:0] res, input logic ovf);
        vec_t v;
        v.len = len; v.sign = s; v.ul = ul; v.bias = bias;
        v.a[0] = a0; v.b[0] = b0; v.a[1] = a1; v.b[1] = b1;
        v.a[2] = a2; v.b[2] = b2; v.a[3] = '0; v.b[3] = '0;
        v.exp_res = res; v.exp_ovf = ovf;
        return v;
    endfunction

    logic [102:0] all_out;
    assign all_out = {op_ready_o, mult_enable_o, mult_a_o, mult_b_o, mult_sign_o,
                      mult_up_or_low_o, busy_o, result_o, result_valid_o, overflow_o};

    initial begin
        bit busy_dropped;
        checks = 0; failures = 0; en_cnt = 0; wide_cnt = 0; en_prev = 1'b0;
        stray_rdy = 1'b0; model_rdy = 1'b0; model_prod = '0; mcnt = 0;
        reset = 1'b1; start_i = 1'b0; len_i = '0; sign_i = 1'b0; up_or_low_i = 1'b0;
        bias_i = '0; op_valid_i = 1'b0; op_a_i = '0; op_b_i = '0;

        vecs[0] = mk(16'd3, 1'b0, 1'b0, 32'd10, 32'd2, 32'd3, 32'd4, 32'd5, 32'd1, 32'd7,
                     32'd43, 1'b0);
`ifdef MAC_SATURATE_EN
        vecs[1] = mk(16'd1, 1'b1, 1'b0, 32'h7FFF_FFF0, 32'd4, 32'd8, 0, 0, 0, 0,
                     32'h7FFF_FFFF, 1'b1);
        vecs[3] = mk(16'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 0, 0,
                     32'hFFFF_FFFF, 1'b1);
        vecs[5] = mk(16'd1, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0,
                     32'h8000_0000, 1'b1);
        vecs[7] = mk(16'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd3, 32'd1, 0, 0,
                     32'hFFFF_FFFF, 1'b1);
`else
        vecs[1] = mk(16'd1, 1'b1, 1'b0, 32'h7FFF_FFF0, 32'd4, 32'd8, 0, 0, 0, 0,
                     32'h8000_0010, 1'b1);
        vecs[3] = mk(16'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 0, 0,
                     32'h0000_0000, 1'b1);
        vecs[5] = mk(16'd1, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0,
                     32'h7FFF_FFFF, 1'b1);
        vecs[7] = mk(16'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd3, 32'd1, 0, 0,
                     32'd3, 1'b1);
`endif
        vecs[2] = mk(16'd2, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFD, 32'd4, 32'd5, 32'hFFFF_FFFE,
                     0, 0, 32'hFFFF_FFEA, 1'b0);
        vecs[4] = mk(16'd1, 1'b0, 1'b1, 32'd5, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, 0,
                     32'd6, 1'b0);
        vecs[6] = mk(16'd1, 1'b1, 1'b1, 32'd1, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, 0,
                     32'd0, 1'b0);

        repeat (3) tick();
        chk("reset_outputs_zero", 32'(all_out != '0), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_job(vecs[i]);

        // Empty job: strobe exactly two cycles after start, result equals bias.
        exp_q.push_back('{res: 32'h1234, ovf: 1'b0, nen: 16'd0});
        drive_start(16'd0, 1'b0, 1'b0, 32'h1234);
        chk("len0_valid_early", 32'(result_valid_o), 32'd0);
        tick();
        chk("len0_valid_at_2", 32'(result_valid_o), 32'd1);
        wait_idle();

        // Stalled operands with stray start / ready pulses in FETCH and ISSUE.
        busy_dropped = 1'b0;
        exp_q.push_back('{res: 32'd14, ovf: 1'b0, nen: 16'd2});
        drive_start(16'd2, 1'b0, 1'b0, 32'd1);
        give_pair(32'd3, 32'd3);
        for (int k = 0; k < 200 && !op_ready_o; k++) begin
            tick();
            if (!busy_o) busy_dropped = 1'b1;
        end
        for (int k = 0; k < 10; k++) begin
            start_i   = (k == 2);
            len_i     = 16'd5;
            bias_i    = 32'h5555;
            stray_rdy = (k == 5);
            tick();
            if (!busy_o) busy_dropped = 1'b1;
        end
        start_i = 1'b0; stray_rdy = 1'b0;
        chk("stall_still_fetch", 32'(op_ready_o), 32'd1);
        give_pair(32'd2, 32'd2);
        start_i = 1'b1; stray_rdy = 1'b1;
        tick();
        start_i = 1'b0; stray_rdy = 1'b0;
        chk("stray_ready_in_issue_ignored", 32'(busy_o & ~op_ready_o), 32'd1);
        for (int k = 0; k < 400 && busy_o; k++) begin
            tick();
            if (busy_o && result_valid_o) busy_dropped = 1'b1;
        end
        chk("stall_idle_timeout", 32'(busy_o), 32'd0);
        chk("busy_held_through_stall", 32'(busy_dropped), 32'd0);

        // Reset while waiting on the multiplier abandons the job silently.
        drive_start(16'd1, 1'b1, 1'b1, 32'd9);
        give_pair(32'd5, 32'd5);
        repeat (5) tick();
        chk("in_wait_before_reset", 32'(busy_o & ~op_ready_o), 32'd1);
        reset = 1'b1;
        #1;
        chk("reset_mid_job_zero", 32'(all_out != '0), 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (40) tick();
        run_job(mk(16'd1, 1'b0, 1'b0, 32'd0, 32'd6, 32'd7, 0, 0, 0, 0, 32'd42, 1'b0));

        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("enable_one_cycle_wide", 32'(wide_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
